// File: rtl/rbm_read_scheduler.sv
// Chunking sequencer for the Avalon-MM memory reader: software programs one
// base/length transfer and this block issues it as go/done chunk commands.
module rbm_read_scheduler #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int CHUNK_BYTES   = 4096
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               avs_s0_address,
  input  logic                     avs_s0_read,
  input  logic                     avs_s0_write,
  input  logic [ADDRESS_WIDTH-1:0] avs_s0_writedata,
  output logic [ADDRESS_WIDTH-1:0] avs_s0_readdata,
  output logic                     avs_s0_readdatavalid,
  output logic                     coe_control_fixed_location,
  output logic [ADDRESS_WIDTH-1:0] coe_control_read_base,
  output logic [ADDRESS_WIDTH-1:0] coe_control_read_length,
  output logic                     coe_control_go,
  input  logic                     coe_control_done,
  input  logic                     coe_control_early_done,
  output logic                     coe_sched_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  localparam logic [ADDRESS_WIDTH-1:0] CHUNK = ADDRESS_WIDTH'(CHUNK_BYTES);

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] base_reg, length_reg, cur_addr_reg, remaining_reg;
  logic [ADDRESS_WIDTH-1:0] read_base_reg, read_length_reg, readdata_reg;
  logic [15:0]              chunk_cnt_reg;
  logic                     done_reg, aborted_reg, error_reg, abort_pending_reg;
  logic                     readdatavalid_reg;

  logic                     start_cmd, abort_cmd, abort_eff;
  logic [ADDRESS_WIDTH-1:0] first_len, addr_after, rem_after, next_len;
  logic [31:0]              status_word;
  logic                     unused_early_done;

  assign unused_early_done = coe_control_early_done;

  // Abort wins over start when both bits arrive in one control write.
  assign start_cmd = avs_s0_write && (avs_s0_address == 2'd2) &&
                     avs_s0_writedata[0] && !avs_s0_writedata[1];
  assign abort_cmd = avs_s0_write && (avs_s0_address == 2'd2) && avs_s0_writedata[1];
  assign abort_eff = abort_pending_reg || abort_cmd;

  assign first_len  = (length_reg > CHUNK) ? CHUNK : length_reg;
  assign addr_after = cur_addr_reg + read_length_reg;
  assign rem_after  = remaining_reg - read_length_reg;
  assign next_len   = (rem_after > CHUNK) ? CHUNK : rem_after;

  assign status_word = {chunk_cnt_reg, 12'd0, error_reg, aborted_reg, done_reg, coe_sched_busy};

  assign avs_s0_readdata            = readdata_reg;
  assign avs_s0_readdatavalid       = readdatavalid_reg;
  assign coe_control_fixed_location = 1'b0;
  assign coe_control_read_base      = read_base_reg;
  assign coe_control_read_length    = read_length_reg;

  always_comb begin
    state_next     = state_reg;
    coe_control_go = 1'b0;
    coe_sched_busy = 1'b1;
    case (state_reg)
      IDLE: begin
        coe_sched_busy = 1'b0;
        if (start_cmd && (length_reg != '0)) state_next = ISSUE;
      end
      ISSUE: begin
        coe_control_go = 1'b1;
        state_next     = WAIT;
      end
      WAIT: begin
        if (coe_control_done) state_next = ((rem_after == '0) || abort_eff) ? IDLE : ISSUE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= IDLE;
      base_reg          <= '0;
      length_reg        <= '0;
      cur_addr_reg      <= '0;
      remaining_reg     <= '0;
      read_base_reg     <= '0;
      read_length_reg   <= '0;
      readdata_reg      <= '0;
      readdatavalid_reg <= 1'b0;
      chunk_cnt_reg     <= '0;
      done_reg          <= 1'b0;
      aborted_reg       <= 1'b0;
      error_reg         <= 1'b0;
      abort_pending_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      readdatavalid_reg <= avs_s0_read;
      // Read sees register values from before any same-cycle write.
      if (avs_s0_read) begin
        case (avs_s0_address)
          2'd0:    readdata_reg <= base_reg;
          2'd1:    readdata_reg <= length_reg;
          2'd2:    readdata_reg <= remaining_reg;
          default: readdata_reg <= ADDRESS_WIDTH'(status_word);
        endcase
      end
      if (state_reg == IDLE && avs_s0_write && avs_s0_address == 2'd0) base_reg   <= avs_s0_writedata;
      if (state_reg == IDLE && avs_s0_write && avs_s0_address == 2'd1) length_reg <= avs_s0_writedata;

      case (state_reg)
        IDLE: begin
          abort_pending_reg <= 1'b0;
          if (start_cmd) begin
            done_reg      <= 1'b0;
            aborted_reg   <= 1'b0;
            chunk_cnt_reg <= '0;
            error_reg     <= (length_reg == '0);
            if (length_reg != '0) begin
              cur_addr_reg    <= base_reg;
              remaining_reg   <= length_reg;
              read_base_reg   <= base_reg;
              read_length_reg <= first_len;
            end
          end
        end
        ISSUE: begin
          if (abort_cmd) abort_pending_reg <= 1'b1;
        end
        WAIT: begin
          if (abort_cmd) abort_pending_reg <= 1'b1;
          if (coe_control_done) begin
            cur_addr_reg  <= addr_after;
            remaining_reg <= rem_after;
            if (chunk_cnt_reg != 16'hFFFF) chunk_cnt_reg <= chunk_cnt_reg + 16'd1;
            if (rem_after == '0) begin
              done_reg          <= 1'b1;
              abort_pending_reg <= 1'b0;
            end else if (abort_eff) begin
              aborted_reg       <= 1'b1;
              abort_pending_reg <= 1'b0;
            end else begin
              read_base_reg   <= addr_after;
              read_length_reg <= next_len;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
